// File: rtl/complex_bfly_addsub.sv
// Radix-2 butterfly add/subtract stage: A+B and A-B on complex operands with
// optional 1/2 scaling, fraction alignment, saturate/wrap and a sticky overflow flag.
module complex_bfly_addsub #(
  parameter int IN_W     = 13,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 13,
  parameter int OUT_FRAC = 8,
  parameter int PIPE     = 2,
  parameter int SAT      = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  a_re,
  input  logic signed [IN_W-1:0]  a_im,
  input  logic signed [IN_W-1:0]  b_re,
  input  logic signed [IN_W-1:0]  b_im,
  input  logic                    scale,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] sum_re,
  output logic signed [OUT_W-1:0] sum_im,
  output logic signed [OUT_W-1:0] dif_re,
  output logic signed [OUT_W-1:0] dif_im,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int XW    = IN_W + 2;
  localparam int WW    = ((XW > OUT_W) ? XW : OUT_W) + 1;
  localparam int PW    = 4 * OUT_W + 1;

  localparam logic signed [WW-1:0] MAX_V = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_V = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [XW-1:0] ONE   = {{(XW-1){1'b0}}, 1'b1};

  // Returns {overflow, formatted value}; overflow is judged on the aligned value
  // before saturation so it is reported identically in saturate and wrap modes.
  function automatic logic [OUT_W:0] fmt(input logic signed [IN_W:0] x, input logic sc);
    logic signed [XW-1:0]    ext;
    logic signed [XW-1:0]    scl;
    logic signed [XW-1:0]    aln;
    logic signed [WW-1:0]    wide;
    logic                    o;
    logic signed [OUT_W-1:0] res;
    ext  = XW'(x);
    scl  = sc ? ((ext + ONE) >>> 1) : ext;
    aln  = scl >>> SHIFT;
    wide = WW'(aln);
    o    = (wide > MAX_V) || (wide < MIN_V);
    if (o && (SAT != 0))
      res = wide[WW-1] ? MIN_V[OUT_W-1:0] : MAX_V[OUT_W-1:0];
    else
      res = wide[OUT_W-1:0];
    return {o, res};
  endfunction

  logic signed [IN_W:0] s_re;
  logic signed [IN_W:0] s_im;
  logic signed [IN_W:0] d_re;
  logic signed [IN_W:0] d_im;

  assign s_re = (IN_W+1)'(a_re) + (IN_W+1)'(b_re);
  assign s_im = (IN_W+1)'(a_im) + (IN_W+1)'(b_im);
  assign d_re = (IN_W+1)'(a_re) - (IN_W+1)'(b_re);
  assign d_im = (IN_W+1)'(a_im) - (IN_W+1)'(b_im);

  logic [OUT_W:0] f_sr;
  logic [OUT_W:0] f_si;
  logic [OUT_W:0] f_dr;
  logic [OUT_W:0] f_di;

  assign f_sr = fmt(s_re, scale);
  assign f_si = fmt(s_im, scale);
  assign f_dr = fmt(d_re, scale);
  assign f_di = fmt(d_im, scale);

  // Stage payload: {overflow, sum_re, sum_im, dif_re, dif_im}
  logic [PW-1:0] pay_in;

  assign pay_in = {f_sr[OUT_W] | f_si[OUT_W] | f_dr[OUT_W] | f_di[OUT_W],
                   f_sr[OUT_W-1:0], f_si[OUT_W-1:0], f_dr[OUT_W-1:0], f_di[OUT_W-1:0]};

  logic [PIPE-1:0] vld;
  logic [PW-1:0]   pay [PIPE];
  logic            adv;
  logic            xfer;

  // Handshake: a transfer happens on any edge where valid && ready. in_ready
  // depends only on out_valid and out_ready, so the whole pipeline advances or
  // stalls as one and in_valid never feeds in_ready combinationally.
  assign out_valid = vld[PIPE-1];
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld <= '0;
      for (int i = 0; i < PIPE; i++) pay[i] <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      pay[0] <= pay_in;
      for (int i = 1; i < PIPE; i++) begin
        vld[i] <= vld[i-1];
        pay[i] <= pay[i-1];
      end
    end
  end

  assign sum_re = pay[PIPE-1][4*OUT_W-1 -: OUT_W];
  assign sum_im = pay[PIPE-1][3*OUT_W-1 -: OUT_W];
  assign dif_re = pay[PIPE-1][2*OUT_W-1 -: OUT_W];
  assign dif_im = pay[PIPE-1][OUT_W-1:0];

  // Set wins over clear when both land on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ovf <= 1'b0;
    else if (xfer && pay[PIPE-1][PW-1])
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

endmodule

// File: tb/tb_complex_bfly_addsub.sv
// Bench for complex_bfly_addsub: saturating and wrapping instances share stimulus,
// results are checked against an integer model through expected queues.
module tb_complex_bfly_addsub;

  localparam int IN_W     = 13;
  localparam int IN_FRAC  = 8;
  localparam int OUT_W    = 13;
  localparam int OUT_FRAC = 8;
  localparam int PIPE     = 2;
  localparam int SHIFT    = IN_FRAC - OUT_FRAC;
  localparam int MAXO     = (1 << (OUT_W-1)) - 1;
  localparam int MINO     = -(1 << (OUT_W-1));
  localparam int EW       = 4 * OUT_W + 1;

  logic CLK = 1'b0;
  logic RST;
  logic in_valid, out_ready, scale, ovf_clr;
  logic signed [IN_W-1:0] a_re, a_im, b_re, b_im;

  logic in_ready, out_valid, ovf;
  logic signed [OUT_W-1:0] sum_re, sum_im, dif_re, dif_im;
  logic in_ready_w, out_valid_w, ovf_w;
  logic signed [OUT_W-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;

  complex_bfly_addsub #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
                        .PIPE(PIPE), .SAT(1)) dut_sat (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  complex_bfly_addsub #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
                        .PIPE(PIPE), .SAT(0)) dut_wrap (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .scale(scale),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .sum_re(sum_re_w), .sum_im(sum_im_w), .dif_re(dif_re_w), .dif_im(dif_im_w),
    .ovf(ovf_w), .ovf_clr(ovf_clr)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w_q[$];
  logic [EW-1:0] mon_e;
  bit exp_ovf, nxt_ovf, prev_stall, acc;
  int base, idx;

  int bp_ar[6] = '{100, -200, 4000, -4000, 500, -600};
  int bp_ai[6] = '{7, 8, 9, -10, 11, 12};
  int bp_br[6] = '{1, 2, 300, -300, 5, 6};
  int bp_bi[6] = '{-1, -2, -3, 4, 5, 6};

  task automatic chk(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int x, input bit sc, input bit sat, output bit o);
    int v;
    v = x;
    if (sc) v = (v + 1) >>> 1;
    v = v >>> SHIFT;
    o = (v > MAXO) || (v < MINO);
    if (o) begin
      if (sat) v = (v > 0) ? MAXO : MINO;
      else begin
        v = v & ((1 << OUT_W) - 1);
        if (v > MAXO) v = v - (1 << OUT_W);
      end
    end
    return v;
  endfunction

  function automatic logic [EW-1:0] expect_of(input bit sat);
    int ar, ai, br, bi, r0, r1, r2, r3;
    bit o0, o1, o2, o3;
    ar = a_re; ai = a_im; br = b_re; bi = b_im;
    r0 = model(ar + br, scale, sat, o0);
    r1 = model(ai + bi, scale, sat, o1);
    r2 = model(ar - br, scale, sat, o2);
    r3 = model(ai - bi, scale, sat, o3);
    return {o0 | o1 | o2 | o3, OUT_W'(r0), OUT_W'(r1), OUT_W'(r2), OUT_W'(r3)};
  endfunction

  function automatic int sx(input logic [OUT_W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check_out(input string pfx, input logic [EW-1:0] e,
                           input logic signed [OUT_W-1:0] sr, si, dr, di);
    chk({pfx, "_sum_re"}, sr, sx(e[4*OUT_W-1 -: OUT_W]));
    chk({pfx, "_sum_im"}, si, sx(e[3*OUT_W-1 -: OUT_W]));
    chk({pfx, "_dif_re"}, dr, sx(e[2*OUT_W-1 -: OUT_W]));
    chk({pfx, "_dif_im"}, di, sx(e[OUT_W-1:0]));
  endtask

  // Scoreboard: push on accepted input, compare front while presented, pop on transfer
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      exp_w_q.delete();
      exp_ovf    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("ovf", ovf, exp_ovf);
      chk("ovf_w", ovf_w, exp_ovf);
      if (prev_stall) chk("stall_hold_valid", out_valid, 1);
      nxt_ovf = ovf_clr ? 1'b0 : exp_ovf;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          check_out("sb", exp_q[0], sum_re, sum_im, dif_re, dif_im);
          if (out_ready) begin
            mon_e = exp_q.pop_front();
            n_popped++;
            if (mon_e[EW-1]) nxt_ovf = 1'b1;
          end
        end
      end
      if (out_valid_w) begin
        if (exp_w_q.size() == 0) chk("sbw_unexpected", 1, 0);
        else begin
          check_out("sbw", exp_w_q[0], sum_re_w, sum_im_w, dif_re_w, dif_im_w);
          if (out_ready) mon_e = exp_w_q.pop_front();
        end
      end
      prev_stall = out_valid && !out_ready;
      exp_ovf    = nxt_ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(expect_of(1'b1));
        exp_w_q.push_back(expect_of(1'b0));
      end
    end
  end

  // Driver tasks
  task automatic set_op(input int ar, input int ai, input int br, input int bi, input bit sc);
    a_re  = IN_W'(ar);
    a_im  = IN_W'(ai);
    b_re  = IN_W'(br);
    b_im  = IN_W'(bi);
    scale = sc;
  endtask

  // Presents one operand with out_ready=1 on an idle pipeline and returns when the result is shown.
  task automatic send_wait(input int ar, input int ai, input int br, input int bi, input bit sc);
    int lat;
    set_op(ar, ai, br, bi, sc);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", lat, PIPE);
  endtask

  function automatic int rnd();
    case ($urandom_range(0, 5))
      0: return 4095;
      1: return -4096;
      default: return int'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_op(0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sum_re", sum_re, 0);
    chk("rst_dif_im", dif_im, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready_w", in_ready_w, 1);
    RST = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    @(posedge CLK); #1;

    // Basic operation
    send_wait(256, -64, 128, 64, 1'b0);
    chk("basic_sum_re", sum_re, 384);
    chk("basic_dif_re", dif_re, 128);
    chk("basic_sum_im", sum_im, 0);
    chk("basic_dif_im", dif_im, -128);
    @(posedge CLK); #1;
    chk("basic_ovf", ovf, 0);

    // Saturate vs wrap
    send_wait(4095, 0, 1, 0, 1'b0);
    chk("sat_sum_re", sum_re, 4095);
    chk("sat_dif_re", dif_re, 4094);
    chk("wrap_valid", out_valid_w, 1);
    chk("wrap_sum_re", sum_re_w, -4096);
    chk("wrap_dif_re", dif_re_w, 4094);
    @(posedge CLK); #1;
    chk("sat_ovf", ovf, 1);
    chk("wrap_ovf", ovf_w, 1);
    ovf_clr = 1'b1;
    @(posedge CLK); #1;
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 0);

    // Sticky flag: set wins over a simultaneous clear
    send_wait(4095, 0, 1, 0, 1'b0);
    ovf_clr = 1'b1;
    @(posedge CLK); #1;
    chk("ovf_set_wins", ovf, 1);
    @(posedge CLK); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr_next", ovf, 0);

    // Scaling with round half up
    send_wait(3, 0, 0, 0, 1'b1);
    chk("scl_sum_re", sum_re, 2);
    chk("scl_dif_re", dif_re, 2);
    send_wait(-3, 0, 0, 0, 1'b1);
    chk("scl_neg_sum_re", sum_re, -1);
    chk("scl_neg_dif_re", dif_re, -1);
    @(posedge CLK); #1;

    // Backpressure: 6 back-to-back operands, out_ready low for 3 cycles mid-stream
    base = n_popped;
    idx  = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 6);
      if (idx < 6) set_op(bp_ar[idx], bp_ai[idx], bp_br[idx], bp_bi[idx], 1'(idx % 2));
      @(negedge CLK);
      if (in_valid && in_ready) idx++;
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    chk("bp_count", n_popped - base, 6);
    chk("bp_q_empty", exp_q.size(), 0);

    // Random stream with random backpressure and clears
    in_valid = 1'b0;
    acc      = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_op(rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      @(negedge CLK);
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (PIPE + 3) begin
      @(posedge CLK); #1;
    end
    chk("rnd_q_empty", exp_q.size(), 0);
    chk("rnd_qw_empty", exp_w_q.size(), 0);

    // Reset mid-stream with two results in flight
    send_wait(4095, 0, 1, 0, 1'b0);
    @(posedge CLK); #1;
    chk("pre_rst_ovf", ovf, 1);
    set_op(10, 20, 30, 40, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    set_op(50, 60, 70, 80, 1'b0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_valid_w", out_valid_w, 0);
    chk("rst_mid_sum_re", sum_re, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_rel_in_ready", in_ready, 1);
    send_wait(256, -64, 128, 64, 1'b0);
    chk("post_rst_sum_re", sum_re, 384);
    chk("post_rst_dif_im", dif_im, -128);
    repeat (PIPE + 2) begin
      @(posedge CLK); #1;
    end
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_qw_empty", exp_w_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
